// File: rtl/timeout_multi.sv
`default_nettype none
// timeout_multi: NCH independent down-counting timeout channels sharing one tick prescaler.
// Rev 1.0 - initial release.
module timeout_multi #(
  parameter int NCH      = 4,
  parameter int CNT_W    = 16,
  parameter int PRESCALE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       start,
  input  logic [NCH-1:0]       stop,
  input  logic [NCH-1:0]       hold,
  input  logic [NCH-1:0]       periodic,
  input  logic [NCH*CNT_W-1:0] load_val,
  output logic [NCH-1:0]       timeout,
  output logic [NCH-1:0]       busy,
  output logic [NCH*CNT_W-1:0] count,
  output logic                 any_timeout
);

  localparam int                PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(PRESCALE - 1);
  localparam logic [0:0]        ST_IDLE = 1'b0;
  localparam logic [0:0]        ST_RUN  = 1'b1;

  logic [PRE_W-1:0] pre;
  logic             tick;
  logic [NCH-1:0]   pulse_nx_all;

  // Free-running tick divider; only reset clears it, so channel starts never shift its phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               pre <= '0;
    else if (pre == PRE_MAX)  pre <= '0;
    else                      pre <= pre + PRE_W'(1);
  end

  assign tick = (pre == PRE_MAX);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [0:0]       state;
    logic [0:0]       state_nx;
    logic             mode;
    logic             mode_nx;
    logic             pulse;
    logic             pulse_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W-1:0] ld;

    assign ld = load_val[i*CNT_W +: CNT_W];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= ST_IDLE;
        cnt   <= '0;
        mode  <= 1'b0;
        pulse <= 1'b0;
      end else begin
        state <= state_nx;
        cnt   <= cnt_nx;
        mode  <= mode_nx;
        pulse <= pulse_nx;
      end
    end

    // stop beats start beats the tick decrement; an expiry pre-empted by either emits no pulse.
    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      mode_nx  = mode;
      pulse_nx = 1'b0;
      if (stop[i]) begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end else if (start[i]) begin
        if (ld != '0) begin
          state_nx = ST_RUN;
          cnt_nx   = ld;
          mode_nx  = periodic[i];
        end else begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
          pulse_nx = 1'b1;
        end
      end else if (state == ST_RUN && tick && !hold[i]) begin
        if (cnt > CNT_W'(1)) begin
          cnt_nx = cnt - CNT_W'(1);
        end else begin
          pulse_nx = 1'b1;
          if (mode && ld != '0) begin
            cnt_nx  = ld;
            mode_nx = periodic[i];
          end else begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
          end
        end
      end
    end

    assign busy[i]                  = (state == ST_RUN);
    assign timeout[i]               = pulse;
    assign count[i*CNT_W +: CNT_W]  = cnt;
    assign pulse_nx_all[i]          = pulse_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) any_timeout <= 1'b0;
    else        any_timeout <= |pulse_nx_all;
  end

endmodule
`default_nettype wire

// File: tb/tb_timeout_multi.sv
`default_nettype none
// tb_timeout_multi: two timeout_multi instances (8-bit/P=1 and 16-bit/P=3) against a deadline-based model.
// Rev 1.0 - initial release.
module tb_timeout_multi;
  localparam int NCH = 4;
  localparam int W0 = 8,  P0 = 1;
  localparam int W1 = 16, P1 = 3;

  typedef struct packed {
    logic [NCH-1:0]       to;
    logic [NCH-1:0]       busy;
    logic [NCH-1:0][15:0] cnt;
    logic                 any;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NCH-1:0]    start_v [2];
  logic [NCH-1:0]    stop_v [2];
  logic [NCH-1:0]    hold_v [2];
  logic [NCH-1:0]    periodic_v [2];
  logic [NCH-1:0]    to_v [2];
  logic [NCH-1:0]    busy_v [2];
  logic              any_v [2];
  logic [NCH*W0-1:0] ld0, cnt0;
  logic [NCH*W1-1:0] ld1, cnt1;

  timeout_multi #(.NCH(NCH), .CNT_W(W0), .PRESCALE(P0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .stop(stop_v[0]), .hold(hold_v[0]),
    .periodic(periodic_v[0]), .load_val(ld0), .timeout(to_v[0]), .busy(busy_v[0]),
    .count(cnt0), .any_timeout(any_v[0]));

  timeout_multi #(.NCH(NCH), .CNT_W(W1), .PRESCALE(P1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .stop(stop_v[1]), .hold(hold_v[1]),
    .periodic(periodic_v[1]), .load_val(ld1), .timeout(to_v[1]), .busy(busy_v[1]),
    .count(cnt1), .any_timeout(any_v[1]));

  int   errors = 0;
  int   checks = 0;
  int   e = 0;
  bit   mon_en = 1'b0;
  exp_t q[2][$];
  int   pl[2][NCH][$];
  bit   act[2][NCH];
  bit   per[2][NCH];
  int   dl[2][NCH];

  task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  function automatic int pval(int d);
    return (d == 0) ? P0 : P1;
  endfunction

  function automatic int get_ld(int d, int c);
    return (d == 0) ? int'(ld0[c*W0 +: W0]) : int'(ld1[c*W1 +: W1]);
  endfunction

  task automatic setld(int d, int c, int L);
    if (d == 0) ld0[c*W0 +: W0] = W0'(L);
    else        ld1[c*W1 +: W1] = W1'(L);
  endtask

  // Each running channel owns an absolute deadline edge; ticks land on edges that are multiples of P.
  task automatic model_edge(int d);
    exp_t x;
    int   p  = pval(d);
    bit   tk = ((e % p) == 0);
    x = '0;
    for (int c = 0; c < NCH; c++) begin
      int L = get_ld(d, c);
      if (stop_v[d][c]) begin
        act[d][c] = 1'b0;
      end else if (start_v[d][c]) begin
        if (L != 0) begin
          act[d][c] = 1'b1;
          per[d][c] = periodic_v[d][c];
          dl[d][c]  = (e / p + L) * p;
        end else begin
          act[d][c] = 1'b0;
          x.to[c]   = 1'b1;
        end
      end else if (act[d][c]) begin
        if (hold_v[d][c]) begin
          if (tk) dl[d][c] += p;
        end else if (e == dl[d][c]) begin
          x.to[c] = 1'b1;
          if (per[d][c] && L != 0) begin
            dl[d][c]  = e + L * p;
            per[d][c] = periodic_v[d][c];
          end else begin
            act[d][c] = 1'b0;
          end
        end
      end
      x.busy[c] = act[d][c];
      x.cnt[c]  = act[d][c] ? 16'(dl[d][c] / p - e / p) : 16'd0;
    end
    x.any = |x.to;
    q[d].push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      e++;
      model_edge(0);
      model_edge(1);
    end
    #1;
  endtask

  task automatic kick(int d, int c, int L, bit p);
    setld(d, c, L);
    periodic_v[d][c] = p;
    start_v[d][c] = 1'b1;
    step();
    start_v[d][c] = 1'b0;
  endtask

  task automatic clr_pulses();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NCH; c++) pl[d][c].delete();
  endtask

  task automatic chk_reset_outputs(string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_to%0d", tag, d), 64'(to_v[d]), 64'd0);
      chk($sformatf("%s_busy%0d", tag, d), 64'(busy_v[d]), 64'd0);
      chk($sformatf("%s_any%0d", tag, d), 64'(any_v[d]), 64'd0);
    end
    chk({tag, "_cnt0"}, 64'(cnt0), 64'd0);
    chk({tag, "_cnt1"}, 64'(cnt1), 64'd0);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      q[d].delete();
      for (int c = 0; c < NCH; c++) act[d][c] = 1'b0;
    end
    e = 0;
  endtask

  // Scoreboard monitor: pops one expected record per DUT per cycle, away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int d = 0; d < 2; d++) begin
          if (q[d].size() != 0) begin
            exp_t x;
            exp_t a;
            x = q[d].pop_front();
            a.to   = to_v[d];
            a.busy = busy_v[d];
            a.any  = any_v[d];
            for (int c = 0; c < NCH; c++)
              a.cnt[c] = (d == 0) ? {8'd0, cnt0[c*W0 +: W0]} : cnt1[c*W1 +: W1];
            chk($sformatf("d%0d_timeout@%0d", d, e), 64'(a.to), 64'(x.to));
            chk($sformatf("d%0d_busy@%0d", d, e), 64'(a.busy), 64'(x.busy));
            chk($sformatf("d%0d_count@%0d", d, e), 64'(a.cnt), 64'(x.cnt));
            chk($sformatf("d%0d_any@%0d", d, e), 64'(a.any), 64'(x.any));
            chk($sformatf("d%0d_any_or@%0d", d, e), 64'(a.any), 64'(|a.to));
            for (int c = 0; c < NCH; c++)
              if (a.to[c] === 1'b1) pl[d][c].push_back(e);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int n;
    for (int d = 0; d < 2; d++) begin
      start_v[d] = '0; stop_v[d] = '0; hold_v[d] = '0; periodic_v[d] = '0;
    end
    ld0 = '0;
    ld1 = '0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // One-shot, start sampled at edge 10 with L=5.
    while (e < 9) step();
    kick(0, 0, 5, 1'b0);
    repeat (8) step();
    chk("oneshot_npulse", 64'(pl[0][0].size()), 64'd1);
    if (pl[0][0].size() == 1) chk("oneshot_edge", 64'(pl[0][0][0]), 64'd15);

    // Periodic on the P=3 instance, load changed mid-run.
    clr_pulses();
    kick(1, 1, 4, 1'b1);
    k = e;
    repeat (40) step();
    setld(1, 1, 2);
    repeat (40) step();
    stop_v[1][1] = 1'b1;
    step();
    stop_v[1][1] = 1'b0;
    n = pl[1][1].size();
    chk("per_npulse_ge6", 64'(n >= 6), 64'd1);
    if (n >= 6) begin
      chk("per_first_window", 64'(pl[1][1][0] - k >= 10 && pl[1][1][0] - k <= 12), 64'd1);
      chk("per_gap_L4", 64'(pl[1][1][1] - pl[1][1][0]), 64'd12);
      chk("per_gap_L2", 64'(pl[1][1][n-1] - pl[1][1][n-2]), 64'd6);
    end

    // Hold for 7 cycles delays an L=10 expiry by 7.
    clr_pulses();
    kick(0, 2, 10, 1'b0);
    k = e;
    repeat (3) step();
    hold_v[0][2] = 1'b1;
    repeat (7) step();
    hold_v[0][2] = 1'b0;
    repeat (10) step();
    chk("hold_npulse", 64'(pl[0][2].size()), 64'd1);
    if (pl[0][2].size() == 1) chk("hold_edge", 64'(pl[0][2][0]), 64'(k + 17));

    // Stop in the expiry cycle.
    clr_pulses();
    kick(0, 3, 4, 1'b0);
    repeat (3) step();
    stop_v[0][3] = 1'b1;
    step();
    stop_v[0][3] = 1'b0;
    chk("stop_exp_count", 64'(cnt0[3*W0 +: W0]), 64'd0);
    repeat (5) step();
    chk("stop_exp_npulse", 64'(pl[0][3].size()), 64'd0);

    // Restart in the expiry cycle.
    clr_pulses();
    kick(0, 3, 4, 1'b0);
    k = e;
    repeat (3) step();
    setld(0, 3, 6);
    start_v[0][3] = 1'b1;
    step();
    start_v[0][3] = 1'b0;
    repeat (10) step();
    chk("restart_npulse", 64'(pl[0][3].size()), 64'd1);
    if (pl[0][3].size() == 1) chk("restart_edge", 64'(pl[0][3][0]), 64'(k + 10));

    // Zero load: single pulse, channel stays idle.
    clr_pulses();
    kick(0, 1, 0, 1'b1);
    k = e;
    chk("zero_busy", 64'(busy_v[0][1]), 64'd0);
    repeat (3) step();
    chk("zero_npulse", 64'(pl[0][1].size()), 64'd1);
    if (pl[0][1].size() == 1) chk("zero_edge", 64'(pl[0][1][0]), 64'(k));

    // Full-range countdown on the 8-bit instance.
    clr_pulses();
    kick(0, 0, 255, 1'b0);
    k = e;
    chk("full_top", 64'(cnt0[W0-1:0]), 64'd255);
    repeat (254) step();
    chk("full_one", 64'(cnt0[W0-1:0]), 64'd1);
    repeat (3) step();
    chk("full_npulse", 64'(pl[0][0].size()), 64'd1);
    if (pl[0][0].size() == 1) chk("full_edge", 64'(pl[0][0][0]), 64'(k + 255));

    // All channels started together with L=3,5,7,9.
    clr_pulses();
    for (int c = 0; c < NCH; c++) begin
      setld(0, c, 3 + 2 * c);
      periodic_v[0][c] = 1'b0;
    end
    start_v[0] = '1;
    step();
    start_v[0] = '0;
    k = e;
    repeat (12) step();
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("conc_npulse%0d", c), 64'(pl[0][c].size()), 64'd1);
      if (pl[0][c].size() == 1) chk($sformatf("conc_edge%0d", c), 64'(pl[0][c][0]), 64'(k + 3 + 2 * c));
    end

    // Randomized traffic on both instances.
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NCH; c++) periodic_v[d][c] = 1'($urandom_range(0, 1));
    repeat (2000) begin
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < NCH; c++) begin
          start_v[d][c] = ($urandom_range(0, 15) == 0);
          stop_v[d][c]  = ($urandom_range(0, 39) == 0);
          if ($urandom_range(0, 9) == 0)  hold_v[d][c] = ~hold_v[d][c];
          if ($urandom_range(0, 19) == 0) setld(d, c, int'($urandom_range(0, 12)));
          if ($urandom_range(0, 49) == 0) periodic_v[d][c] = ~periodic_v[d][c];
        end
      end
      step();
    end
    for (int d = 0; d < 2; d++) begin
      start_v[d] = '0; stop_v[d] = '0; hold_v[d] = '0;
    end

    // Reset mid-run with every channel busy.
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NCH; c++) setld(d, c, 9);
      periodic_v[d] = '1;
      start_v[d] = '1;
    end
    step();
    for (int d = 0; d < 2; d++) start_v[d] = '0;
    repeat (5) step();
    chk("midrun_busy_pre", 64'(busy_v[0] & busy_v[1]), 64'hf);
    mon_en = 1'b0;
    model_reset();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrun");
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    clr_pulses();
    repeat (30) step();
    n = 0;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NCH; c++) n += pl[d][c].size();
    chk("post_reset_npulse", 64'(n), 64'd0);

    @(negedge clk);
    #1;
    chk("sb_drain0", 64'(q[0].size()), 64'd0);
    chk("sb_drain1", 64'(q[1].size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/timeout_multi.md
# timeout_multi

Parametrised multi-channel timeout timer for the elevator controller. It replaces the single fixed timeout with NCH independent down-counters, such as door-open, travel-limit and idle-return timers. Each channel has a programmable load value, one-shot or periodic mode, hold and cancel. All channels share a common tick prescaler and run in the `clk` domain beside the main controller FSM, which starts and consumes the timeouts.

## Interface
- `NCH`, 4: number of independent channels (1..16).
- `CNT_W`, 16: counter width per channel, in ticks.
- `PRESCALE`, 1: clock cycles per tick (≥1). 1 means one tick per cycle.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  NCH  per-channel start/restart strobe, level-sampled each cycle.
- `stop`  in  NCH  per-channel cancel strobe.
- `hold`  in  NCH  per-channel pause; the counter freezes while high.
- `periodic`  in  NCH  per-channel mode; sampled at start and at each expiry. 1 = auto-reload, 0 = one-shot.
- `load_val`  in  NCH*CNT_W  per-channel timeout length in ticks; channel i occupies bits [i*CNT_W +: CNT_W].
- `timeout`  out  NCH  per-channel one-cycle expiry pulse.
- `busy`  out  NCH  channel is in RUN.
- `count`  out  NCH*CNT_W  current remaining ticks per channel; 0 when idle.
- `any_timeout`  out  1  OR of `timeout`.

## Operation
- **Prescaler**
  - Shared free-running counter `pre`, counting 0..PRESCALE-1 and wrapping.
  - `tick` = (`pre` == PRESCALE-1), so it is constant 1 when PRESCALE=1.
  - The prescaler is never reset by `start` or `stop`, only by `rst_n`.
- **Channel FSM states:** IDLE, RUN.
- **Priority per channel, per cycle:** `stop` > `start` > tick decrement.
- **`stop`**
  - Go to IDLE and set count to 0. No `timeout` pulse.
  - Applies in any state; a stop in IDLE is a no-op.
- **`start` with `load_val` ≠ 0**
  - Set count to `load_val`, go to RUN, latch `periodic`.
  - Applies from IDLE or RUN (RUN means restart).
- **`start` with `load_val` = 0**
  - Channel stays or returns to IDLE with count 0.
  - `timeout` pulses once on the next cycle, regardless of mode.
- **RUN decrement**
  - On `tick` with `hold`=0:
    - count > 1: count = count - 1.
    - count == 1: assert `timeout`. If periodic: count = current `load_val`, stay in RUN; if that `load_val` is 0, go to IDLE instead. If one-shot: count = 0, go to IDLE.
  - With `hold`=1 the count and state are frozen, and ticks are lost rather than accumulated.
- **Simultaneous events**
  - Expiry and `stop` in the same cycle: no pulse, channel goes IDLE.
  - Expiry and `start` in the same cycle: no pulse, channel reloads from `start`.
  - Hold does not block `stop` or `start`.
- **Independence:** channels are fully independent. Only `tick` is shared.
- **Arithmetic:** unsigned CNT_W. Count never underflows, and never goes below 0 in RUN.

## Timing
- **Reset values (`rst_n`=0, asynchronous):**
  - `pre`=0.
  - All channels in IDLE.
  - `count`=0, `busy`=0, `timeout`=0, `any_timeout`=0.
- **Reset deassertion:** synchronous to the design. The first tick occurs PRESCALE cycles after release.
- **Registered outputs:** all outputs are registered. No combinational path from inputs to outputs.
- **Start latency:** `start` sampled at edge k gives `busy`=1 and `count`=L after edge k.
- **PRESCALE=1, no hold:** `timeout` is high for exactly the cycle after edge k+L. `busy` drops at that same edge in one-shot mode.
- **PRESCALE=P:** the expiry pulse lands between (L-1)*P+1 and L*P cycles after edge k, depending on prescaler phase.
- **Periodic mode:** expiry pulses are spaced exactly L*P cycles apart, with no slip.
- **Pulse width:** `timeout` is never high for two consecutive cycles on the same channel, except for periodic L=1 with P=1, where it is continuously high.
- **Reset mid-run:** immediate return to the reset values, and any pending pulse is lost.

## Test plan
- **Reset behaviour:** reset asserted mid-run on all channels -> all outputs 0 immediately. After release, no `timeout` without a `start`.
- **One-shot:** NCH=4, P=1, start ch0 with L=5 at edge 10 -> `count` 5,4,3,2,1, `timeout[0]` high only after edge 15, `busy[0]` low from edge 15. Other channels stay idle.
- **Periodic with prescale:** P=3, ch1 L=4 periodic -> `timeout[1]` pulses every 12 cycles. Changing `load_val` to 2 takes effect at the next expiry, then pulses every 6 cycles.
- **Hold, stop and collision:**
  - Hold ch2 for 7 cycles during an L=10 run -> expiry delayed by exactly 7 cycles.
  - `stop` asserted in the expiry cycle -> no pulse, `count`=0.
  - `start` asserted in the expiry cycle -> no pulse, reload.
- **Edge cases:**
  - `load_val`=0 start -> single pulse next cycle, `busy` stays 0.
  - `load_val`=2^CNT_W-1 -> full-range countdown with no wrap. Spot-check `count` at the top and at 1.
- **Concurrent channels:** all channels start on the same cycle with L=3,5,7,9 -> four distinct pulses, and `any_timeout` matches the OR of `timeout` every cycle.
